// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the BNN layer datapath.
// A neuron sum carries 11 bits of headroom above the adder-tree input width.
package bnn_pkg;

    localparam int WIDTH_IN_DEFAULT = 8;

    function automatic int sum_w(input int width_in);
        return width_in + 11;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SUM_W_DEFAULT = sum_w(WIDTH_IN_DEFAULT);

    typedef logic signed [SUM_W_DEFAULT-1:0] sum_t;

endpackage

// File: rtl/bnn_neuron_binarize_if.sv
// Neuron-sum input stream and activation-vector output stream of the binarize stage.
// Output side: a vector moves on any edge where act_valid && act_ready; act_vec holds while act_valid && !act_ready.
interface bnn_neuron_binarize_if
    import bnn_pkg::*;
#(
    parameter int SUM_W     = SUM_W_DEFAULT,
    parameter int N_NEURONS = 100
);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [SUM_W-1:0] sum_in;
    logic [N_NEURONS-1:0]    act_vec;
    logic                    act_valid;
    logic                    act_ready;

    modport master (
        output in_valid,
        output sum_in,
        output act_ready,
        input  in_ready,
        input  act_vec,
        input  act_valid
    );

    modport slave (
        input  in_valid,
        input  sum_in,
        input  act_ready,
        output in_ready,
        output act_vec,
        output act_valid
    );

endinterface

// File: rtl/bnn_valid_delay.sv
// Valid token delay line that mirrors the fixed-latency adder pipeline.
// Also keeps a running count of tokens currently inside the line.
module bnn_valid_delay #(
    parameter int DEPTH = 6,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output logic             v_d,
    output logic [CNT_W-1:0] inflight
);

    logic [DEPTH-1:0] v_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_pipe   <= '0;
            inflight <= '0;
        end else begin
            v_pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                v_pipe[i] <= v_pipe[i-1];
            end
            case ({din, v_pipe[DEPTH-1]})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    assign v_d = v_pipe[DEPTH-1];

endmodule

// File: rtl/bnn_neuron_binarize.sv
// Thresholds each neuron sum from the add784 tree, packs the bits into a layer vector
// and offers it downstream through a single output register.
module bnn_neuron_binarize
    import bnn_pkg::*;
#(
    parameter int WIDTH_IN    = 8,
    parameter int ADD_LATENCY = 6,
    parameter int N_NEURONS   = 100,
    localparam int SUM_W      = sum_w(WIDTH_IN),
    localparam int IDX_W      = idx_w(N_NEURONS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bnn_neuron_binarize_if.slave    bus,
    input  logic                    thr_we,
    input  logic [IDX_W-1:0]        thr_addr,
    input  logic signed [SUM_W-1:0] thr_data,
    output logic                    overflow
);

    localparam int CNT_W  = $clog2(ADD_LATENCY + 1);
    localparam int PEND_W = ((IDX_W > CNT_W) ? IDX_W : CNT_W) + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_NEURONS - 1);
    localparam logic [PEND_W-1:0] PEND_LIMIT = PEND_W'(N_NEURONS - 1);

    logic signed [SUM_W-1:0] thr [N_NEURONS];
    logic [IDX_W-1:0]        idx;
    logic [N_NEURONS-1:0]    acc;
    logic [N_NEURONS-1:0]    acc_next;
    logic [N_NEURONS-1:0]    out_vec;
    logic                    out_valid;
    logic                    ovf;
    logic                    in_ready_int;
    logic                    accept;
    logic                    v_d;
    logic                    act_bit;
    logic                    complete;
    logic                    drain;
    logic [CNT_W-1:0]        inflight;
    logic [PEND_W-1:0]       pending;

    bnn_valid_delay #(
        .DEPTH (ADD_LATENCY),
        .CNT_W (CNT_W)
    ) u_valid_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (accept),
        .v_d      (v_d),
        .inflight (inflight)
    );

    // Neurons already committed to the current vector: binarized plus still in the adder.
    // Holding back the last neuron while the output is stuck keeps completion from overrunning it.
    assign pending      = PEND_W'(idx) + PEND_W'(inflight);
    assign in_ready_int = !(out_valid && !bus.act_ready && (pending >= PEND_LIMIT));
    assign accept       = bus.in_valid && in_ready_int;

    assign act_bit  = (bus.sum_in >= thr[idx]);
    assign complete = v_d && (idx == LAST_IDX);
    assign drain    = out_valid && bus.act_ready;

    always_comb begin
        acc_next      = acc;
        acc_next[idx] = act_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            acc       <= '0;
            out_vec   <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (v_d) begin
                if (complete) begin
                    idx <= '0;
                    acc <= '0;
                end else begin
                    idx <= idx + 1'b1;
                    acc <= acc_next;
                end
            end
            if (complete) begin
                out_vec   <= acc_next;
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (bus.in_valid && !in_ready_int) begin
                ovf <= 1'b1;
            end
        end
    end

    // Flop array rather than RAM: needs async clear and a same-cycle read at idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                thr[i] <= '0;
            end
        end else if (thr_we && (int'(thr_addr) < N_NEURONS)) begin
            thr[thr_addr] <= thr_data;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.act_vec   = out_vec;
    assign bus.act_valid = out_valid;
    assign overflow      = ovf;

endmodule

// File: tb/tb_bnn_neuron_binarize.sv
// Directed bench for bnn_neuron_binarize with 4 neurons and a 3-cycle adder model.
module tb_bnn_neuron_binarize;
    import bnn_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       thr_we;
    logic [1:0] thr_addr;
    sum_t       thr_data;
    logic       overflow;
    sum_t       op_sum;
    sum_t       sum_pipe [3];
    int         total = 0;
    int         bad   = 0;

    bnn_neuron_binarize_if #(.SUM_W(19), .N_NEURONS(4)) bus ();

    bnn_neuron_binarize #(
        .WIDTH_IN    (8),
        .ADD_LATENCY (3),
        .N_NEURONS   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .thr_we   (thr_we),
        .thr_addr (thr_addr),
        .thr_data (thr_data),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Stand-in for the adder tree: every operand reappears on sum_in three cycles later.
    always @(posedge clk) begin
        sum_pipe[0] <= op_sum;
        sum_pipe[1] <= sum_pipe[0];
        sum_pipe[2] <= sum_pipe[1];
    end
    assign bus.sum_in = sum_pipe[2];

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.act_ready = 1'b0;
        thr_we        = 1'b0;
        thr_addr      = '0;
        thr_data      = '0;
        op_sum        = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_thr(input logic [1:0] a, input sum_t d);
        thr_we   = 1'b1;
        thr_addr = a;
        thr_data = d;
        @(negedge clk);
        thr_we = 1'b0;
    endtask

    task automatic send_vec(input sum_t s0, input sum_t s1, input sum_t s2, input sum_t s3);
        sum_t s [4];
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            op_sum       = s[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_vec(output logic [3:0] vec, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.act_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vec = bus.act_vec;
    endtask

    task automatic drain();
        bus.act_ready = 1'b1;
        @(negedge clk);
        bus.act_ready = 1'b0;
    endtask

    // Upstream that honours in_ready; returns how many tokens went in.
    task automatic feed_gated(input sum_t toks [8], input int n_tok, input int n_cyc, output int k);
        k = 0;
        for (int i = 0; i < n_cyc; i++) begin
            @(negedge clk);
            #1;
            if (k < n_tok && bus.in_ready === 1'b1) begin
                bus.in_valid = 1'b1;
                op_sum       = toks[k];
                k++;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.act_valid !== 1'b0) begin bad++; $display("FAIL rst_act_valid: got %b want 0", bus.act_valid); end
        total++; if (bus.act_vec !== 4'b0000) begin bad++; $display("FAIL rst_act_vec: got %b want 0000", bus.act_vec); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_basic();
        send_vec(-19'sd5, 19'sd0, 19'sd7, -19'sd1);
        repeat (2) @(negedge clk);
        total++; if (bus.act_valid !== 1'b0) begin bad++; $display("FAIL basic_early: act_valid got %b want 0", bus.act_valid); end
        @(negedge clk);
        total++; if (bus.act_valid !== 1'b1) begin bad++; $display("FAIL basic_latency: act_valid got %b want 1", bus.act_valid); end
        total++; if (bus.act_vec !== 4'b0110) begin bad++; $display("FAIL basic_vec: got %b want 0110", bus.act_vec); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready: got %b want 1", bus.in_ready); end
        drain();
        total++; if (bus.act_valid !== 1'b0) begin bad++; $display("FAIL basic_drain: act_valid got %b want 0", bus.act_valid); end
    endtask

    task automatic test_threshold();
        logic [3:0] vec;
        bit         ok;
        write_thr(2'd2, 19'sd10);
        write_thr(2'd0, -19'sd3);
        send_vec(-19'sd3, 19'sd0, 19'sd10, -19'sd1);
        wait_vec(vec, ok);
        total++; if (!ok) begin bad++; $display("FAIL thr_tie_timeout: act_valid got 0 want 1"); end
        total++; if (vec !== 4'b0111) begin bad++; $display("FAIL thr_tie_vec: got %b want 0111", vec); end
        drain();
        send_vec(-19'sd4, 19'sd0, 19'sd9, 19'sd0);
        wait_vec(vec, ok);
        total++; if (!ok) begin bad++; $display("FAIL thr_below_timeout: act_valid got 0 want 1"); end
        total++; if (vec !== 4'b1010) begin bad++; $display("FAIL thr_below_vec: got %b want 1010", vec); end
        drain();
    endtask

    task automatic test_backpressure();
        sum_t       toks [8];
        int         k;
        logic [3:0] vec;
        bit         ok;
        do_reset();
        toks = '{19'sd1, -19'sd1, 19'sd1, -19'sd1, -19'sd1, -19'sd1, 19'sd1, 19'sd1};
        feed_gated(toks, 8, 12, k);
        total++; if (k !== 7) begin bad++; $display("FAIL bp_accepted: got %0d want 7", k); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
        total++; if (bus.act_valid !== 1'b1) begin bad++; $display("FAIL bp_act_valid: got %b want 1", bus.act_valid); end
        total++; if (bus.act_vec !== 4'b0101) begin bad++; $display("FAIL bp_vec: got %b want 0101", bus.act_vec); end
        repeat (3) @(negedge clk);
        total++; if (bus.act_vec !== 4'b0101) begin bad++; $display("FAIL bp_vec_hold: got %b want 0101", bus.act_vec); end
        bus.act_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        bus.in_valid = 1'b1;
        op_sum       = toks[7];
        @(negedge clk);
        bus.act_ready = 1'b0;
        bus.in_valid  = 1'b0;
        total++; if (bus.act_valid !== 1'b0) begin bad++; $display("FAIL bp_one_transfer: act_valid got %b want 0", bus.act_valid); end
        wait_vec(vec, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_second_timeout: act_valid got 0 want 1"); end
        total++; if (vec !== 4'b1100) begin bad++; $display("FAIL bp_second_vec: got %b want 1100", vec); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_overflow: got %b want 0", overflow); end
        drain();
    endtask

    task automatic test_back_to_back();
        sum_t       toks [12];
        logic [3:0] exp_vecs [3];
        logic       exp_v;
        do_reset();
        toks = '{19'sd1, 19'sd2, 19'sd3, 19'sd4,
                 -19'sd1, 19'sd0, -19'sd1, 19'sd0,
                 19'sd5, -19'sd5, 19'sd5, -19'sd5};
        exp_vecs = '{4'b1111, 4'b1010, 4'b0101};
        bus.act_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_v = (i == 7 || i == 11 || i == 15);
            total++; if (bus.act_valid !== exp_v) begin bad++; $display("FAIL b2b_valid cycle %0d: got %b want %b", i, bus.act_valid, exp_v); end
            if (exp_v) begin
                total++;
                if (bus.act_vec !== exp_vecs[(i - 7) / 4]) begin
                    bad++; $display("FAIL b2b_vec cycle %0d: got %b want %b", i, bus.act_vec, exp_vecs[(i - 7) / 4]);
                end
            end
            if (i < 12) begin
                bus.in_valid = 1'b1;
                op_sum       = toks[i];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.act_ready = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        sum_t       toks [8];
        int         k;
        logic [3:0] vec;
        bit         ok;
        do_reset();
        toks = '{19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd1, -19'sd1, 19'sd1, 19'sd0};
        feed_gated(toks, 7, 10, k);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL ovf_blocked: in_ready got %b want 0", bus.in_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before: got %b want 0", overflow); end
        total++; if (bus.act_vec !== 4'b1111) begin bad++; $display("FAIL ovf_first_vec: got %b want 1111", bus.act_vec); end
        bus.in_valid = 1'b1;
        op_sum       = -19'sd9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        repeat (3) @(negedge clk);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        bus.act_ready = 1'b1;
        #1;
        bus.in_valid = 1'b1;
        op_sum       = 19'sd2;
        @(negedge clk);
        bus.act_ready = 1'b0;
        bus.in_valid  = 1'b0;
        wait_vec(vec, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_second_timeout: act_valid got 0 want 1"); end
        total++; if (vec !== 4'b1101) begin bad++; $display("FAIL ovf_dropped_input: vec got %b want 1101", vec); end
        drain();
    endtask

    task automatic test_reset_midop();
        logic [3:0] vec;
        bit         ok;
        write_thr(2'd1, 19'sd5);
        send_vec(19'sd0, 19'sd0, 19'sd0, 19'sd0);
        wait_vec(vec, ok);
        total++; if (vec !== 4'b1101 || !ok) begin bad++; $display("FAIL mid_pre_vec: got %b valid %b want 1101 valid 1", vec, ok); end
        bus.in_valid = 1'b1;
        op_sum       = 19'sd0;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.act_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", bus.act_valid); end
        total++; if (bus.act_vec !== 4'b0000) begin bad++; $display("FAIL mid_rst_vec: got %b want 0000", bus.act_vec); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", bus.in_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_rst_overflow: got %b want 0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_vec(19'sd3, 19'sd3, -19'sd1, -19'sd1);
        wait_vec(vec, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_post_timeout: act_valid got 0 want 1"); end
        total++; if (vec !== 4'b0011) begin bad++; $display("FAIL mid_post_vec: got %b want 0011", vec); end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_threshold();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
